gray_counter: RTL and testbench
===============================

Name: gray_counter

Overview:
- Free-running, parameterised Gray-code up-counter that advances one code per clock.
- Consecutive outputs, including the terminal-to-zero wrap, differ in exactly one bit.
- Intended as a pointer/sequence source for clock-domain-crossing logic, e.g. FIFO read/write pointers, and for glitch-safe state encoding.
- Output is fully registered, with no combinational path from any input to gray_out.

Parameters:
- WIDTH, default 4, counter width in bits; legal range 2..32. Code space is 2^WIDTH values.

Ports:
- clk  input  1  rising-edge clock; all state changes on posedge clk only.
- rst  input  1  synchronous, active-high reset; sampled on posedge clk.
- gray_out  output  WIDTH  registered Gray-code count value.

Behaviour:
- State: internal binary register bin[WIDTH-1:0] and output register gray_out[WIDTH-1:0].
- Reset: on posedge clk with rst=1, bin <= 0 and gray_out <= 0.
  - Reset has priority over counting.
  - Reset asserted mid-count returns the output to 0 at that edge; no partial advance.
- Before the first reset edge, the state is undefined; no power-up value is guaranteed.
- Count: on each posedge clk with rst=0:
  - bin <= bin + 1, modulo 2^WIDTH.
  - gray_out <= (bin+1) ^ ((bin+1) >> 1).
  - gray_out is therefore always the Gray encoding of the current bin, and both registers update on the same edge.
- Latency: the first posedge with rst=0 produces gray_out = 1 (0001 for WIDTH=4). Each subsequent edge advances one code.
- WIDTH=4 sequence: 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, then back to 0000.
- Wrap-around:
  - From the all-ones binary value (Gray 1000 for WIDTH=4), the next edge gives 0000, a single MSB toggle.
  - No stall and no overflow flag in the base build.
- Invariants:
  - Hamming distance between consecutive non-reset outputs is exactly 1.
  - The period is exactly 2^WIDTH clocks.
- No enable input; the counter advances every clock while out of reset.

Optional Feature:
- Macro: GRAY_COUNTER_BIN_OUT_EN.
- When defined, two extra outputs are added:
  - bin_out, output, WIDTH bits: the registered binary count, equal to the internal bin and in the same cycle as gray_out.
  - wrap, output, 1 bit: registered pulse, high for exactly one cycle when the count transitions from all-ones to 0 (gray_out becomes 0 by counting, not by reset).
- Reset values: bin_out=0, wrap=0.
- Reset does not raise wrap.
- When not defined, these ports do not exist and gray_out behaviour is identical.

Test Plan:
- Reset then run: 10 ns clock, rst=1 across the first posedge, released before the second -> gray_out=0000 after reset, then 0001, 0011, 0010 on the next three edges.
- Full period, WIDTH=4: 16 edges after reset release -> exact 16-code sequence listed above, and gray_out=0000 again on the 16th edge.
- One-bit-change check: run 40 cycles; at every non-reset edge, popcount(gray_out_prev ^ gray_out) == 1, including the 1000->0000 wrap.
- Mid-count reset: run to gray_out=0110, assert rst for one edge -> 0000 on that edge; release -> 0001 on the next edge.
- Parameter sweep, WIDTH=2 and WIDTH=8:
  - WIDTH=2 gives 00, 01, 11, 10, 00.
  - WIDTH=8 returns to 0 after exactly 256 edges, with gray_out == bin ^ (bin>>1) against a reference model every cycle.
- GRAY_COUNTER_BIN_OUT_EN defined:
  - bin_out tracks 0, 1, 2, ... in lockstep with gray_out.
  - wrap=1 only in the cycle where bin_out returns 15->0, and is 0 after reset.

Source files
------------

// File: rtl/gray_counter.sv
// Free-running Gray-code up-counter; the binary count is kept internally and re-encoded each edge.
// Optional GRAY_COUNTER_BIN_OUT_EN exposes the binary count (bin_out) and a wrap pulse (wrap).
module gray_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
`ifdef GRAY_COUNTER_BIN_OUT_EN
    output logic [WIDTH-1:0] bin_out,
    output logic             wrap,
`endif
    output logic [WIDTH-1:0] gray_out
);

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;

    // Gray code is derived from the incremented value so both registers land on the same edge.
    always_comb begin
        bin_d  = bin_q + WIDTH'(1);
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
        end
    end

    assign gray_out = gray_q;

`ifdef GRAY_COUNTER_BIN_OUT_EN
    logic wrap_q, wrap_d;

    // Pulses only on the counting transition all-ones -> 0; reset clears it instead.
    always_comb begin
        wrap_d = &bin_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign bin_out = bin_q;
    assign wrap    = wrap_q;
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter: WIDTH=4, 2 and 8 instances share one clock and reset.
module tb_gray_counter;

    logic       clk;
    logic       rst;
    logic [3:0] g4;
    logic [1:0] g2;
    logic [7:0] g8;
`ifdef GRAY_COUNTER_BIN_OUT_EN
    logic [3:0] b4;
    logic       w4;
    logic [1:0] b2;
    logic       w2;
    logic [7:0] b8;
    logic       w8;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    logic [3:0] seq4 [16];

    gray_counter #(.WIDTH(4)) u_dut4 (
        .clk      (clk),
        .rst      (rst),
`ifdef GRAY_COUNTER_BIN_OUT_EN
        .bin_out  (b4),
        .wrap     (w4),
`endif
        .gray_out (g4)
    );

    gray_counter #(.WIDTH(2)) u_dut2 (
        .clk      (clk),
        .rst      (rst),
`ifdef GRAY_COUNTER_BIN_OUT_EN
        .bin_out  (b2),
        .wrap     (w2),
`endif
        .gray_out (g2)
    );

    gray_counter #(.WIDTH(8)) u_dut8 (
        .clk      (clk),
        .rst      (rst),
`ifdef GRAY_COUNTER_BIN_OUT_EN
        .bin_out  (b8),
        .wrap     (w8),
`endif
        .gray_out (g8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset across one posedge; returns at the following negedge with rst low.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp4 [3];
        exp4 = '{4'h1, 4'h3, 4'h2};
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (g4 !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_g4: got %b expected %b", g4, 4'h0);
        end
        n_cmp++;
        if (g2 !== 2'h0) begin
            n_fail++;
            $display("FAIL reset_g2: got %b expected %b", g2, 2'h0);
        end
        n_cmp++;
        if (g8 !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_g8: got %b expected %b", g8, 8'h0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (g4 !== exp4[i]) begin
                n_fail++;
                $display("FAIL run_after_reset[%0d]: got %b expected %b", i, g4, exp4[i]);
            end
        end
    endtask

    task automatic test_full_period();
        seq4 = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            n_cmp++;
            if (g4 !== seq4[i % 16]) begin
                n_fail++;
                $display("FAIL full_period[%0d]: got %b expected %b", i, g4, seq4[i % 16]);
            end
        end
    endtask

    task automatic test_one_bit_change();
        logic [3:0] prev4;
        logic [7:0] prev8;
        do_reset();
        prev4 = g4;
        prev8 = g8;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n_cmp++;
            if ($countones(prev4 ^ g4) != 1) begin
                n_fail++;
                $display("FAIL one_bit_w4[%0d]: got %b after %b expected 1 bit change",
                         i, g4, prev4);
            end
            n_cmp++;
            if ($countones(prev8 ^ g8) != 1) begin
                n_fail++;
                $display("FAIL one_bit_w8[%0d]: got %b after %b expected 1 bit change",
                         i, g8, prev8);
            end
            prev4 = g4;
            prev8 = g8;
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        repeat (4) @(negedge clk);
        n_cmp++;
        if (g4 !== 4'b0110) begin
            n_fail++;
            $display("FAIL mid_reset_pre: got %b expected %b", g4, 4'b0110);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (g4 !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_reset_clear: got %b expected %b", g4, 4'b0000);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (g4 !== 4'b0001) begin
            n_fail++;
            $display("FAIL mid_reset_resume: got %b expected %b", g4, 4'b0001);
        end
    endtask

    task automatic test_width2();
        logic [1:0] exp2 [5];
        exp2 = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            n_cmp++;
            if (g2 !== exp2[i]) begin
                n_fail++;
                $display("FAIL width2[%0d]: got %b expected %b", i, g2, exp2[i]);
            end
        end
    endtask

    task automatic test_width8();
        logic [7:0] mbin;
        logic [7:0] mgray;
        int         errs;
        do_reset();
        mbin = 8'h0;
        errs = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            mbin  = mbin + 8'h1;
            mgray = mbin ^ (mbin >> 1);
            n_cmp++;
            if (g8 !== mgray) begin
                n_fail++;
                errs++;
                if (errs <= 5)
                    $display("FAIL width8_model[%0d]: got %h expected %h", i, g8, mgray);
            end
        end
        n_cmp++;
        if (g8 !== 8'h00) begin
            n_fail++;
            $display("FAIL width8_return_zero: got %h expected %h", g8, 8'h00);
        end
    endtask

`ifdef GRAY_COUNTER_BIN_OUT_EN
    task automatic test_bin_out();
        logic [3:0] ebin;
        logic       ewrap;
        // Advance off zero first so the reset below clears a live count.
        repeat (15) @(negedge clk);
        do_reset();
        n_cmp++;
        if (b4 !== 4'h0 || w4 !== 1'b0) begin
            n_fail++;
            $display("FAIL bin_out_reset: got bin=%h wrap=%b expected bin=0 wrap=0", b4, w4);
        end
        ebin = 4'h0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            ebin  = ebin + 4'h1;
            ewrap = (i == 16);
            n_cmp++;
            if (b4 !== ebin) begin
                n_fail++;
                $display("FAIL bin_out[%0d]: got %h expected %h", i, b4, ebin);
            end
            n_cmp++;
            if (w4 !== ewrap) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got %b expected %b", i, w4, ewrap);
            end
            n_cmp++;
            if (g4 !== (ebin ^ (ebin >> 1))) begin
                n_fail++;
                $display("FAIL bin_gray_lockstep[%0d]: got %b expected %b",
                         i, g4, ebin ^ (ebin >> 1));
            end
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        test_reset();
        test_full_period();
        test_one_bit_change();
        test_mid_reset();
        test_width2();
        test_width8();
`ifdef GRAY_COUNTER_BIN_OUT_EN
        test_bin_out();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
